// File: rtl/stage_sequencer.sv
// Multi-cycle instruction sequencer: walks a one-hot stage enable through NUM_STAGES stages per
// instruction, with per-stage ready handshake, stall, halt, single-step, watchdog and retire count.
module stage_sequencer #(
    parameter int unsigned NUM_STAGES = 4,
    parameter int unsigned MAX_WAIT   = 15,
    parameter int unsigned CNT_W      = 16,
    localparam int unsigned IdxW      = $clog2(NUM_STAGES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stall,
    input  logic [NUM_STAGES-1:0] stage_ready,
    input  logic                  halt_req,
    input  logic                  step_mode,
    input  logic                  step,
    output logic                  en_PM,
    output logic [NUM_STAGES-1:0] en_stage,
    output logic [IdxW-1:0]       stage_idx,
    output logic                  busy,
    output logic                  halted,
    output logic                  err,
    output logic [CNT_W-1:0]      retire_cnt
);

    localparam int unsigned WaitW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_STAGES - 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'((MAX_WAIT == 0) ? 0 : MAX_WAIT - 1);
    localparam logic [NUM_STAGES-1:0] StageOne = NUM_STAGES'(1);

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StWaitStep,
        StHalted,
        StError
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_d;
    logic [WaitW-1:0]  wait_q, wait_d;
    logic              halt_pend_q, halt_pend_d;
    logic [CNT_W-1:0]  retire_d;

    always_comb begin
        state_d     = state_q;
        idx_d       = stage_idx;
        wait_d      = wait_q;
        halt_pend_d = halt_pend_q;
        retire_d    = retire_cnt;
        unique case (state_q)
            StIdle, StHalted: begin
                if (start) begin
                    state_d = StRun;
                    idx_d   = '0;
                end
            end
            StRun: begin
                if (stall) begin
                    // A halt request is remembered even while frozen so the pulse is not lost.
                    halt_pend_d = halt_pend_q | halt_req;
                end else if (stage_ready[stage_idx]) begin
                    wait_d = '0;
                    if (stage_idx == LastIdx) begin
                        retire_d = retire_cnt + 1'b1;
                        idx_d    = '0;
                        if (halt_pend_q || halt_req) begin
                            state_d     = StHalted;
                            halt_pend_d = 1'b0;
                        end else if (step_mode) begin
                            state_d = StWaitStep;
                        end
                    end else begin
                        idx_d       = stage_idx + 1'b1;
                        halt_pend_d = halt_pend_q | halt_req;
                    end
                end else begin
                    wait_d      = wait_q + 1'b1;
                    halt_pend_d = halt_pend_q | halt_req;
                    if (MAX_WAIT != 0 && wait_q == WaitLast) begin
                        state_d = StError;
                    end
                end
            end
            StWaitStep: begin
                if (halt_req) begin
                    state_d = StHalted;
                end else if (step || !step_mode) begin
                    state_d = StRun;
                    idx_d   = '0;
                end
            end
            StError: ;
            default: state_d = StError;
        endcase
    end

    // Outputs are registered from the next-state values so they track the state registers exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            stage_idx   <= '0;
            wait_q      <= '0;
            halt_pend_q <= 1'b0;
            retire_cnt  <= '0;
            en_PM       <= 1'b1;
            en_stage    <= '0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            err         <= 1'b0;
        end else begin
            state_q     <= state_d;
            stage_idx   <= idx_d;
            wait_q      <= wait_d;
            halt_pend_q <= halt_pend_d;
            retire_cnt  <= retire_d;
            en_PM       <= (state_d == StIdle) || (state_d == StWaitStep) ||
                           ((state_d == StRun) && (idx_d == LastIdx));
            en_stage    <= (state_d == StRun) ? (StageOne << idx_d) : '0;
            busy        <= (state_d == StRun);
            halted      <= (state_d == StHalted);
            err         <= (state_d == StError);
        end
    end

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: a cycle reference model pushes expected outputs to a queue each
// cycle; they are popped and compared after the clock edge, alongside directed scenario checks.
module tb_stage_sequencer;

    localparam int NS = 4;
    localparam int MAXW = 15;
    localparam int CW = 8;  // narrow counter so the wrap is reachable quickly

    localparam int SIdle = 0, SRun = 1, SStep = 2, SHalt = 3, SErr = 4;

    typedef struct packed {
        logic [NS-1:0] en_stage;
        logic [1:0]    idx;
        logic          en_pm;
        logic          busy;
        logic          halted;
        logic          err;
        logic [CW-1:0] ret;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset, start, stall, halt_req, step_mode, step;
    logic [NS-1:0] stage_ready;
    logic          en_PM, busy, halted, err;
    logic [NS-1:0] en_stage;
    logic [1:0]    stage_idx;
    logic [CW-1:0] retire_cnt;

    int n_checks = 0;
    int n_errors = 0;
    exp_t exp_q[$];

    int m_state, m_idx, m_wait, m_ret;
    bit m_pend;

    stage_sequencer #(
        .NUM_STAGES(NS),
        .MAX_WAIT  (MAXW),
        .CNT_W     (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stall      (stall),
        .stage_ready(stage_ready),
        .halt_req   (halt_req),
        .step_mode  (step_mode),
        .step       (step),
        .en_PM      (en_PM),
        .en_stage   (en_stage),
        .stage_idx  (stage_idx),
        .busy       (busy),
        .halted     (halted),
        .err        (err),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic model_step();
        if (reset) begin
            m_state = SIdle; m_idx = 0; m_wait = 0; m_pend = 0; m_ret = 0;
        end else begin
            case (m_state)
                SIdle, SHalt: if (start) begin m_state = SRun; m_idx = 0; end
                SRun: begin
                    if (stall) begin
                        m_pend = m_pend | halt_req;
                    end else if (stage_ready[m_idx]) begin
                        m_wait = 0;
                        if (m_idx == NS - 1) begin
                            m_ret = (m_ret + 1) % (1 << CW);
                            m_idx = 0;
                            if (m_pend || halt_req) begin
                                m_state = SHalt;
                                m_pend  = 0;
                            end else if (step_mode) begin
                                m_state = SStep;
                            end
                        end else begin
                            m_idx++;
                            m_pend = m_pend | halt_req;
                        end
                    end else begin
                        m_pend = m_pend | halt_req;
                        m_wait++;
                        if (m_wait == MAXW) m_state = SErr;
                    end
                end
                SStep: begin
                    if (halt_req) m_state = SHalt;
                    else if (step || !step_mode) begin m_state = SRun; m_idx = 0; end
                end
                default: ;
            endcase
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.en_stage = (m_state == SRun) ? NS'(1 << m_idx) : '0;
        e.idx      = 2'(m_idx);
        e.en_pm    = (m_state == SIdle) || (m_state == SStep) ||
                     ((m_state == SRun) && (m_idx == NS - 1));
        e.busy     = (m_state == SRun);
        e.halted   = (m_state == SHalt);
        e.err      = (m_state == SErr);
        e.ret      = CW'(m_ret);
        return e;
    endfunction

    task automatic tick();
        exp_t e;
        model_step();
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("sb_en_stage", en_stage, e.en_stage);
        check("sb_stage_idx", stage_idx, e.idx);
        check("sb_en_pm", en_PM, e.en_pm);
        check("sb_busy", busy, e.busy);
        check("sb_halted", halted, e.halted);
        check("sb_err", err, e.err);
        check("sb_retire", retire_cnt, e.ret);
    endtask

    initial begin
        reset = 1; start = 0; stall = 0; halt_req = 0; step_mode = 0; step = 0; stage_ready = '0;
        tick(); tick();
        check("rst_en_pm", en_PM, 1);
        check("rst_en_stage", en_stage, 0);
        check("rst_retire", retire_cnt, 0);
        reset = 0;
        tick();
        check("idle_hold", busy, 0);

        // Free-running with every stage ready.
        start = 1; tick(); start = 0;
        check("run_s0", en_stage, 4'b0001);
        stage_ready = 4'hF;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("seq_en_stage", en_stage, 32'(1 << ((i + 1) % 4)));
            check("seq_en_pm", en_PM, 32'(((i + 1) % 4) == 3));
        end
        check("seq_retire", retire_cnt, 3);

        // Stage 2 waits three extra cycles: seven-cycle instruction.
        tick(); tick();
        check("s2_enter", en_stage, 4'b0100);
        stage_ready = 4'b1011;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s2_hold", en_stage, 4'b0100);
        end
        stage_ready = 4'hF;
        tick();
        check("s2_done", en_stage, 4'b1000);
        tick();
        check("s2_retire", retire_cnt, 4);
        check("s2_err", err, 0);

        // Stall in stage 1 freezes the stage and the watchdog, even with ready asserted.
        tick();
        stage_ready = 4'h0;
        tick(); tick();
        stall = 1; stage_ready = 4'hF;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_idx", stage_idx, 1);
        end
        stall = 0; stage_ready = 4'h0;
        for (int i = 0; i < 12; i++) tick();
        check("stall_wd_paused", err, 0);
        stage_ready = 4'hF;
        tick();
        check("stall_resume", stage_idx, 2);
        tick(); tick();
        check("stall_retire", retire_cnt, 5);

        // Halt request mid-instruction completes the instruction first.
        tick();
        halt_req = 1; tick(); halt_req = 0;
        tick();
        check("halt_not_yet", halted, 0);
        tick();
        check("halt_set", halted, 1);
        check("halt_retire", retire_cnt, 6);
        tick(); tick();
        check("halt_stay", halted, 1);
        start = 1; tick(); start = 0;
        check("halt_restart", en_stage, 4'b0001);

        // Single-step mode.
        step_mode = 1;
        for (int i = 0; i < 4; i++) tick();
        check("step_wait_busy", busy, 0);
        check("step_wait_pm", en_PM, 1);
        check("step_retire1", retire_cnt, 7);
        for (int i = 0; i < 3; i++) tick();
        check("step_parked", en_stage, 0);
        step = 1; tick(); step = 0;
        check("step_go", en_stage, 4'b0001);
        for (int i = 0; i < 4; i++) tick();
        check("step_one_more", busy, 0);
        check("step_retire2", retire_cnt, 8);
        halt_req = 1; step = 1; tick(); halt_req = 0; step = 0;
        check("step_halt_prio", halted, 1);
        step_mode = 0;
        start = 1; tick(); start = 0;

        // Retire counter wrap.
        for (int i = 0; i < 991; i++) tick();
        check("wrap_pre", retire_cnt, 8'hFF);
        tick();
        check("wrap_zero", retire_cnt, 0);

        // Watchdog: stage 0 ready low for MAX_WAIT cycles.
        stage_ready = 4'h0;
        for (int i = 0; i < 14; i++) tick();
        check("wd_not_yet", err, 0);
        tick();
        check("wd_err", err, 1);
        check("wd_no_enable", en_stage, 0);
        check("wd_no_pm", en_PM, 0);
        start = 1; stage_ready = 4'hF;
        for (int i = 0; i < 3; i++) tick();
        start = 0;
        check("wd_sticky", err, 1);
        reset = 1; tick(); reset = 0;
        check("wd_reset_err", err, 0);
        check("wd_reset_pm", en_PM, 1);

        // Reset mid-instruction abandons it without retiring.
        start = 1; tick(); start = 0;
        tick(); tick(); tick();
        reset = 1; tick(); reset = 0;
        check("rst_mid_retire", retire_cnt, 0);
        check("rst_mid_stage", en_stage, 0);
        tick();

        check("sb_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
